// File: rtl/addsub_pipe_nbit_pkg.sv
// Shared types and defaults for the pipelined add/subtract unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package addsub_pipe_nbit_pkg;

    // Datapath width shared with the surrounding FIR stages.
    localparam int DATA_WIDTH     = 16;
    localparam int NUM_STAGES_DEF = 4;
    localparam bit SIGNED_SAT_DEF = 1'b1;

    // Bit 0 selects subtract, bit 1 selects saturation.
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ADD_SAT = 2'b10,
        OP_SUB_SAT = 2'b11
    } op_e;

    function automatic logic op_is_sub(input op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_sat(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry-chain segment: sum = a + b + cin, plus segment MSBs for overflow.
// Latency: combinational.
// Backpressure: none (pure logic, the enclosing pipeline stage holds it).
// Ports: a, b operand segments; cin carry in; sum, cout; a_msb, b_msb top operand bits.
module addsub_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             a_msb,
    output logic             b_msb
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
    assign a_msb       = a[SEG_W-1];
    assign b_msb       = b[SEG_W-1];

endmodule

// File: rtl/addsub_pipe_nbit.sv
// Pipelined add/sub (wrap/saturate) with carry and overflow flags; carry chain split per stage.
// Latency: NUM_STAGES cycles accept-to-valid_o, one op per cycle.
// Backpressure: whole pipe stalls when valid_o && !ready_i; ready_o = !valid_o || ready_i.
// Ports: clk_i, rst_i (async, high); valid_i/ready_o/a_i/b_i/op_i in; valid_o/ready_i/s_o/carry_o/ovf_o out.
module addsub_pipe_nbit #(
    parameter int DATA_WIDTH = addsub_pipe_nbit_pkg::DATA_WIDTH,
    parameter int NUM_STAGES = addsub_pipe_nbit_pkg::NUM_STAGES_DEF,
    parameter bit SIGNED_SAT = addsub_pipe_nbit_pkg::SIGNED_SAT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [1:0]            op_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] s_o,
    output logic                  carry_o,
    output logic                  ovf_o
);
    import addsub_pipe_nbit_pkg::*;

    localparam int W     = DATA_WIDTH;
    localparam int SEG_W = DATA_WIDTH / NUM_STAGES;
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] S_MAX = ~S_MIN;

    if ((NUM_STAGES < 1) || (NUM_STAGES > DATA_WIDTH)) begin : g_bad_stages
        $error("addsub_pipe_nbit: NUM_STAGES must be in 1..DATA_WIDTH");
    end
    if ((DATA_WIDTH % NUM_STAGES) != 0) begin : g_bad_width
        $error("addsub_pipe_nbit: DATA_WIDTH must be divisible by NUM_STAGES");
    end

    // Stage registers. Index k holds the result of carry segment k; the last
    // index drives the outputs. Operands ride along so later stages can pick
    // their own segment; st_s accumulates finished low segments.
    logic         st_vld [NUM_STAGES];
    op_e          st_op  [NUM_STAGES];
    logic [W-1:0] st_a   [NUM_STAGES];
    logic [W-1:0] st_b   [NUM_STAGES];
    logic [W-1:0] st_s   [NUM_STAGES];
    logic         st_c   [NUM_STAGES];
    logic         ovf_q;

    logic         nxt_vld [NUM_STAGES];
    op_e          nxt_op  [NUM_STAGES];
    logic [W-1:0] nxt_a   [NUM_STAGES];
    logic [W-1:0] nxt_b   [NUM_STAGES];
    logic [W-1:0] nxt_s   [NUM_STAGES];
    logic         nxt_c   [NUM_STAGES];
    logic         nxt_ovf;

    logic adv;

    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic         in_vld;
        op_e          in_op;
        logic [W-1:0] in_a;
        logic [W-1:0] in_b;
        logic [W-1:0] in_s;
        logic         in_c;
        logic [SEG_W-1:0] seg_sum;
        logic         seg_cout;
        logic         seg_a_msb;
        logic         seg_b_msb;
        logic [W-1:0] s_mix;

        if (k == 0) begin : g_in
            // Subtract is A + ~B + 1: invert B once here and seed carry-in.
            assign in_vld = valid_i;
            assign in_op  = op_e'(op_i);
            assign in_a   = a_i;
            assign in_b   = op_is_sub(op_e'(op_i)) ? ~b_i : b_i;
            assign in_s   = '0;
            assign in_c   = op_is_sub(op_e'(op_i));
        end else begin : g_in
            assign in_vld = st_vld[k-1];
            assign in_op  = st_op[k-1];
            assign in_a   = st_a[k-1];
            assign in_b   = st_b[k-1];
            assign in_s   = st_s[k-1];
            assign in_c   = st_c[k-1];
        end

        addsub_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a     (in_a[k*SEG_W +: SEG_W]),
            .b     (in_b[k*SEG_W +: SEG_W]),
            .cin   (in_c),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .a_msb (seg_a_msb),
            .b_msb (seg_b_msb)
        );

        always_comb begin
            s_mix                      = in_s;
            s_mix[k*SEG_W +: SEG_W]    = seg_sum;
        end

        assign nxt_vld[k] = in_vld;
        assign nxt_op[k]  = in_op;
        assign nxt_a[k]   = in_a;
        assign nxt_b[k]   = in_b;
        assign nxt_c[k]   = seg_cout;

        if (k == NUM_STAGES - 1) begin : g_last
            logic         sgn_ovf;
            logic         is_sub;
            logic         is_sat;
            logic [W-1:0] s_fin;

            // Top segment sees the full-word MSBs, so signed overflow is
            // decided here from the operand signs and the sum sign.
            assign sgn_ovf = (seg_a_msb == seg_b_msb) && (seg_sum[SEG_W-1] != seg_a_msb);
            assign is_sub  = op_is_sub(in_op);
            assign is_sat  = op_is_sat(in_op);

            always_comb begin
                s_fin = s_mix;
                if (is_sat) begin
                    if (SIGNED_SAT) begin
                        if (sgn_ovf) begin
                            s_fin = seg_a_msb ? S_MIN : S_MAX;
                        end
                    end else begin
                        if (!is_sub && seg_cout) begin
                            s_fin = '1;
                        end else if (is_sub && !seg_cout) begin
                            s_fin = '0;
                        end
                    end
                end
            end

            assign nxt_s[k] = s_fin;
            // Unsigned mode reports carry for add and borrow (no carry) for sub.
            assign nxt_ovf  = SIGNED_SAT ? sgn_ovf : (is_sub ? !seg_cout : seg_cout);
        end else begin : g_mid
            assign nxt_s[k] = s_mix;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                st_vld[k] <= 1'b0;
                st_op[k]  <= OP_ADD;
                st_a[k]   <= '0;
                st_b[k]   <= '0;
                st_s[k]   <= '0;
                st_c[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                st_vld[k] <= nxt_vld[k];
                st_op[k]  <= nxt_op[k];
                st_a[k]   <= nxt_a[k];
                st_b[k]   <= nxt_b[k];
                st_s[k]   <= nxt_s[k];
                st_c[k]   <= nxt_c[k];
            end
            ovf_q <= nxt_ovf;
        end
    end

    assign valid_o = st_vld[NUM_STAGES-1];
    assign s_o     = st_s[NUM_STAGES-1];
    assign carry_o = st_c[NUM_STAGES-1];
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// Bench for addsub_pipe_nbit: three instances sharing stimulus
// (W=16/N=4 signed sat, W=16/N=4 unsigned sat, W=16/N=1 signed sat).
// Expected results are {ovf, carry, s} pushed on accept and popped on output transfer.
module tb_addsub_pipe_nbit;
    import addsub_pipe_nbit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  op = '0;

    logic        m_ready, m_valid, m_c, m_ovf;
    logic [15:0] m_s;
    logic        z_ready, z_valid, z_c, z_ovf;
    logic [15:0] z_s;
    logic        u_ready, u_valid, u_c, u_ovf;
    logic [15:0] u_s;

    always #5 clk = ~clk;

    addsub_pipe_nbit #(.DATA_WIDTH(16), .NUM_STAGES(4), .SIGNED_SAT(1'b1)) u_main (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(m_ready),
        .a_i(a), .b_i(b), .op_i(op), .valid_o(m_valid), .ready_i(ready_i),
        .s_o(m_s), .carry_o(m_c), .ovf_o(m_ovf));

    addsub_pipe_nbit #(.DATA_WIDTH(16), .NUM_STAGES(4), .SIGNED_SAT(1'b0)) u_uns (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(z_ready),
        .a_i(a), .b_i(b), .op_i(op), .valid_o(z_valid), .ready_i(ready_i),
        .s_o(z_s), .carry_o(z_c), .ovf_o(z_ovf));

    addsub_pipe_nbit #(.DATA_WIDTH(16), .NUM_STAGES(1), .SIGNED_SAT(1'b1)) u_one (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(u_ready),
        .a_i(a), .b_i(b), .op_i(op), .valid_o(u_valid), .ready_i(ready_i),
        .s_o(u_s), .carry_o(u_c), .ovf_o(u_ovf));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full-width arithmetic on {ovf, carry, s}.
    function automatic logic [17:0] model(input logic [1:0] o, input logic [15:0] x,
                                          input logic [15:0] y, input bit ss);
        logic [15:0] yb;
        logic [16:0] full;
        logic [15:0] s;
        logic        c, sov, ov;
        yb   = o[0] ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {16'h0000, o[0]};
        s    = full[15:0];
        c    = full[16];
        sov  = (x[15] == yb[15]) && (s[15] != x[15]);
        ov   = ss ? sov : (o[0] ? ~c : c);
        if (o[1]) begin
            if (ss) begin
                if (sov) s = x[15] ? 16'h8000 : 16'h7FFF;
            end else if (!o[0] && c) begin
                s = 16'hFFFF;
            end else if (o[0] && !c) begin
                s = 16'h0000;
            end
        end
        return {ov, c, s};
    endfunction

    logic [17:0] cur_m = '0;
    logic [17:0] cur_z = '0;
    logic [17:0] exp_m [$];
    logic [17:0] exp_z [$];
    logic [17:0] e_m, e_z;
    int          n_in = 0, n_out_m = 0, n_out_z = 0;
    logic        held_v = 1'b0;
    logic [15:0] held_s = '0;

    // Monitor: samples on the falling edge, i.e. what the next rising edge transfers.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && m_valid) check("hold_s", m_s, held_s);
            held_v = m_valid && !ready_i;
            held_s = m_s;
            if (m_valid && ready_i) begin
                n_out_m++;
                if (exp_m.size() == 0) check("m_unexpected", 1, 0);
                else begin
                    e_m = exp_m.pop_front();
                    check("m_s", m_s, e_m[15:0]);
                    check("m_carry", m_c, e_m[16]);
                    check("m_ovf", m_ovf, e_m[17]);
                end
            end
            if (z_valid && ready_i) begin
                n_out_z++;
                if (exp_z.size() == 0) check("z_unexpected", 1, 0);
                else begin
                    e_z = exp_z.pop_front();
                    check("z_s", z_s, e_z[15:0]);
                    check("z_carry", z_c, e_z[16]);
                    check("z_ovf", z_ovf, e_z[17]);
                end
            end
            if (valid_i && m_ready) begin
                n_in++;
                exp_m.push_back(cur_m);
                exp_z.push_back(cur_z);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one op and hold it until the 4-stage instances accept it.
    task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [17:0] em, input logic [17:0] ez);
        bit acc;
        acc     = 1'b0;
        valid_i = 1'b1;
        op      = o;
        a       = x;
        b       = y;
        cur_m   = em;
        cur_z   = ez;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = m_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        valid_i = 1'b0;
    endtask

    task automatic drain;
        ready_i = 1'b1;
        valid_i = 1'b0;
        for (int i = 0; i < 40 && (exp_m.size() != 0 || exp_z.size() != 0); i++) tick;
        tick;
        check("drain_m", exp_m.size(), 0);
        check("drain_z", exp_z.size(), 0);
    endtask

    int base_in, base_out_m, base_out_z;

    initial begin
        rst = 1'b1;
        #12;
        check("rst_valid", m_valid, 0);
        check("rst_s", m_s, 0);
        check("rst_carry", m_c, 0);
        check("rst_ovf", m_ovf, 0);
        check("rst_ready", m_ready, 1);
        check("rst_n1_valid", u_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        // Test 1: latency of 4 on the main instance, 1 on the single-stage one.
        ready_i = 1'b1;
        send(OP_ADD, 16'h00FF, 16'h0001, {1'b0, 1'b0, 16'h0100}, {1'b0, 1'b0, 16'h0100});
        check("t1_n1_valid", u_valid, 1);
        check("t1_n1_s", u_s, 16'h0100);
        check("t1_early_valid", m_valid, 0);
        tick;
        tick;
        check("t1_valid_c3", m_valid, 0);
        tick;
        check("t1_valid_c4", m_valid, 1);
        check("t1_s", m_s, 16'h0100);
        check("t1_carry", m_c, 0);
        check("t1_ovf", m_ovf, 0);
        tick;
        check("t1_valid_c5", m_valid, 0);
        drain;

        // Tests 2 and 3: wrap/sat corners, back to back. {ovf, carry, s}.
        send(OP_SUB,     16'h0000, 16'h0001, {1'b0, 1'b0, 16'hFFFF}, {1'b1, 1'b0, 16'hFFFF});
        send(OP_SUB_SAT, 16'h0000, 16'h0001, {1'b0, 1'b0, 16'hFFFF}, {1'b1, 1'b0, 16'h0000});
        send(OP_ADD_SAT, 16'h7FFF, 16'h0001, {1'b1, 1'b0, 16'h7FFF}, {1'b0, 1'b0, 16'h8000});
        send(OP_SUB_SAT, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h8000}, {1'b0, 1'b1, 16'h7FFF});
        send(OP_ADD,     16'h7FFF, 16'h0001, {1'b1, 1'b0, 16'h8000}, {1'b0, 1'b0, 16'h8000});
        drain;

        // Test 5: fill with ready_i low, stall 5 cycles, then release with new traffic.
        base_out_m = n_out_m;
        ready_i = 1'b0;
        send(OP_ADD,     16'h1234, 16'h1111, {1'b0, 1'b0, 16'h2345}, {1'b0, 1'b0, 16'h2345});
        send(OP_SUB,     16'h5000, 16'h1000, {1'b0, 1'b1, 16'h4000}, {1'b0, 1'b1, 16'h4000});
        send(OP_ADD,     16'hFFFF, 16'h0001, {1'b0, 1'b1, 16'h0000}, {1'b1, 1'b1, 16'h0000});
        send(OP_ADD_SAT, 16'hFFFF, 16'h0001, {1'b0, 1'b1, 16'h0000}, {1'b1, 1'b1, 16'hFFFF});
        valid_i = 1'b1;
        op      = OP_SUB_SAT;
        a       = 16'h0005;
        b       = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_ready_low", m_ready, 0);
            check("t5_valid_held", m_valid, 1);
            check("t5_s_held", m_s, 16'h2345);
            tick;
        end
        ready_i = 1'b1;
        #1;
        check("t5_ready_release", m_ready, 1);
        send(OP_SUB_SAT, 16'h0005, 16'h0003, {1'b0, 1'b1, 16'h0002}, {1'b0, 1'b1, 16'h0002});
        send(OP_ADD,     16'h8000, 16'h8000, {1'b1, 1'b1, 16'h0000}, {1'b1, 1'b1, 16'h0000});
        send(OP_ADD_SAT, 16'h8000, 16'h8000, {1'b1, 1'b1, 16'h8000}, {1'b1, 1'b1, 16'hFFFF});
        send(OP_SUB,     16'h0003, 16'h0005, {1'b0, 1'b0, 16'hFFFE}, {1'b1, 1'b0, 16'hFFFE});
        check("t5_streaming", m_valid, 1);
        drain;
        check("t5_outputs", n_out_m - base_out_m, 8);

        // Test 4: random traffic with random valid_i/ready_i.
        base_in    = n_in;
        base_out_m = n_out_m;
        base_out_z = n_out_z;
        for (int cyc = 0; cyc < 8000 && (n_in - base_in) < 1000; cyc++) begin
            valid_i = ($urandom_range(3) != 0);
            ready_i = ($urandom_range(2) != 0);
            op      = 2'($urandom_range(3));
            a       = ($urandom_range(7) == 0) ? 16'h7FFF : 16'($urandom);
            b       = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
            cur_m   = model(op, a, b, 1'b1);
            cur_z   = model(op, a, b, 1'b0);
            tick;
        end
        drain;
        check("rand_accepted", n_in - base_in, 1000);
        check("rand_in_eq_out_m", n_out_m - base_out_m, n_in - base_in);
        check("rand_in_eq_out_z", n_out_z - base_out_z, n_in - base_in);

        // Test 6: asynchronous reset with ops in flight.
        ready_i = 1'b1;
        send(OP_ADD, 16'h0001, 16'h0001, {1'b0, 1'b0, 16'h0002}, {1'b0, 1'b0, 16'h0002});
        send(OP_ADD, 16'h0002, 16'h0002, {1'b0, 1'b0, 16'h0004}, {1'b0, 1'b0, 16'h0004});
        send(OP_ADD, 16'h0003, 16'h0003, {1'b0, 1'b0, 16'h0006}, {1'b0, 1'b0, 16'h0006});
        #3;
        rst = 1'b1;
        #1;
        check("t6_valid_async", m_valid, 0);
        check("t6_s_async", m_s, 0);
        check("t6_uns_valid_async", z_valid, 0);
        check("t6_n1_valid_async", u_valid, 0);
        exp_m.delete();
        exp_z.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("t6_no_stale", m_valid, 0);
        end
        send(OP_ADD, 16'h00FF, 16'h0001, {1'b0, 1'b0, 16'h0100}, {1'b0, 1'b0, 16'h0100});
        check("t6_n1_valid", u_valid, 1);
        check("t6_n1_s", u_s, 16'h0100);
        check("t6_n1_carry", u_c, 0);
        check("t6_n1_ovf", u_ovf, 0);
        tick;
        check("t6_n1_valid_drop", u_valid, 0);
        drain;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
